dram_dump_reader: RTL and testbench

- Read-side counterpart to the core's DRAM write path.
- After the core asserts End, the block takes ownership of the DRAM address port and sweeps a fixed address window, reading each 32-bit word.
- It streams each word out on a UART 8N1 line, MSB byte first, so results can be dumped to a host.
- Sits at top level beside core1, DRAM and IRAM; the top level muxes DRAM addr with dump_sel.

---
 rtl/dump_pkg.sv | 39 +++
 rtl/uart_tx_8n1.sv | 68 ++++++
 rtl/dram_dump_reader.sv | 157 +++++++++++++++
 tb/tb_dram_dump_reader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dump_pkg.sv
// Shared types and constants for the DRAM dump reader and its UART transmitter.
package dump_pkg;

  localparam int unsigned ADDR_W         = 12;
  localparam int unsigned DATA_W         = 32;
  // One wider than the address so a full 4096-word sweep can be counted.
  localparam int unsigned WORDS_W        = 13;
  localparam int unsigned BYTES_PER_WORD = DATA_W / 8;

  // 8N1 framing: start bit, 8 data bits LSB first, one stop bit.
  localparam int unsigned FRAME_BITS = 10;
  localparam logic        START_BIT  = 1'b0;
  localparam logic        STOP_BIT   = 1'b1;
  localparam logic        IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWait,
    StLatch,
    StSend,
    StNext,
    StFin
  } dump_state_e;

  // Byte idx 0 is the most significant byte, so a word goes out MSB byte first.
  function automatic logic [7:0] word_byte(input logic [DATA_W-1:0] word,
                                           input logic [1:0]        idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter. A start request in the final cycle of a stop bit is
// accepted, so consecutive bytes go out with no idle gap between frames.
module uart_tx_8n1
  import dump_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       byte_done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        BIT_LAST  = 4'(FRAME_BITS - 1);

  logic                  r_tx;
  logic                  r_busy;
  logic [FRAME_BITS-1:0] r_frame;
  logic [BAUD_W-1:0]     r_baud;
  logic [3:0]            r_bit;

  logic w_bit_end;
  logic w_frame_end;

  assign w_bit_end   = r_busy && (r_baud == BAUD_LAST);
  assign w_frame_end = w_bit_end && (r_bit == BIT_LAST);

  // Baud and bit counters; the frame register shifts right so bit 0 always drives next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx    <= IDLE_LEVEL;
      r_busy  <= 1'b0;
      r_frame <= '1;
      r_baud  <= '0;
      r_bit   <= '0;
    end else if (start) begin
      r_frame <= {STOP_BIT, data, START_BIT};
      r_tx    <= START_BIT;
      r_busy  <= 1'b1;
      r_baud  <= '0;
      r_bit   <= '0;
    end else if (r_busy) begin
      if (w_bit_end) begin
        r_baud <= '0;
        if (w_frame_end) begin
          r_busy <= 1'b0;
          r_tx   <= IDLE_LEVEL;
        end else begin
          r_bit   <= r_bit + 4'd1;
          r_frame <= {1'b1, r_frame[FRAME_BITS-1:1]};
          r_tx    <= r_frame[1];
        end
      end else begin
        r_baud <= r_baud + BAUD_W'(1);
      end
    end
  end

  assign tx        = r_tx;
  assign busy      = r_busy;
  assign byte_done = w_frame_end;

endmodule

// File: rtl/dram_dump_reader.sv
// After the core raises End, sweeps a DRAM address window and streams every
// 32-bit word out over UART 8N1, most significant byte first.
module dram_dump_reader
  import dump_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  START_ADDR   = 12'h000,
  parameter logic [WORDS_W-1:0] WORD_COUNT   = 13'd16,
  parameter int unsigned        CLKS_PER_BIT = 434,
  parameter int unsigned        RD_LAT       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              End,
  input  logic [DATA_W-1:0] q,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              dump_sel,
  output logic              busy,
  output logic              done,
  output logic              tx
);

  // A zero latency would never leave StWait cleanly; treat it as one cycle.
  localparam logic [7:0] LAT_LOAD = (RD_LAT == 0) ? 8'd1 : 8'(RD_LAT);

  dump_state_e r_state, w_state_next;

  logic                r_end_d;
  logic [ADDR_W-1:0]   r_addr, w_addr_next;
  logic [WORDS_W-1:0]  r_words_left, w_words_next;
  logic [7:0]          r_wait_cnt, w_wait_next;
  logic [DATA_W-1:0]   r_shift, w_shift_next;
  logic [1:0]          r_byte_idx, w_byte_next;

  logic       w_start_edge;
  logic       w_uart_start;
  logic [7:0] w_uart_data;
  logic       w_uart_busy;
  logic       w_byte_done;

  assign w_start_edge = End && !r_end_d;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_end_d      <= 1'b0;
      r_addr       <= START_ADDR;
      r_words_left <= '0;
      r_wait_cnt   <= '0;
      r_shift      <= '0;
      r_byte_idx   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_end_d      <= End;
      r_addr       <= w_addr_next;
      r_words_left <= w_words_next;
      r_wait_cnt   <= w_wait_next;
      r_shift      <= w_shift_next;
      r_byte_idx   <= w_byte_next;
    end
  end

  // Next-state logic and UART byte sequencing.
  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_words_next = r_words_left;
    w_wait_next  = r_wait_cnt;
    w_shift_next = r_shift;
    w_byte_next  = r_byte_idx;
    w_uart_start = 1'b0;
    w_uart_data  = word_byte(r_shift, r_byte_idx);

    unique case (r_state)
      StIdle: begin
        if (w_start_edge) begin
          w_addr_next  = START_ADDR;
          w_words_next = WORD_COUNT;
          w_state_next = (WORD_COUNT == '0) ? StFin : StAddr;
        end
      end
      StAddr: begin
        w_wait_next  = LAT_LOAD;
        w_state_next = StWait;
      end
      StWait: begin
        w_wait_next = r_wait_cnt - 8'd1;
        if (r_wait_cnt <= 8'd1) begin
          w_state_next = StLatch;
        end
      end
      StLatch: begin
        w_shift_next = q;
        w_byte_next  = 2'd0;
        w_uart_start = 1'b1;
        w_uart_data  = q[31:24];
        w_state_next = StSend;
      end
      StSend: begin
        if (w_byte_done) begin
          if (r_byte_idx == 2'(BYTES_PER_WORD - 1)) begin
            w_state_next = StNext;
          end else begin
            // Restart the UART in the stop bit's last cycle to keep frames back-to-back.
            w_byte_next  = r_byte_idx + 2'd1;
            w_uart_start = 1'b1;
            w_uart_data  = word_byte(r_shift, r_byte_idx + 2'd1);
          end
        end
      end
      StNext: begin
        w_words_next = r_words_left - WORDS_W'(1);
        w_addr_next  = r_addr + ADDR_W'(1);
        w_state_next = (r_words_left == WORDS_W'(1)) ? StFin : StAddr;
      end
      StFin: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Status outputs decode straight from the state so reset clears them at once.
  always_comb begin
    busy     = 1'b0;
    dump_sel = 1'b0;
    done     = 1'b0;
    unique case (r_state)
      StAddr, StWait, StLatch, StSend, StNext: begin
        busy     = 1'b1;
        dump_sel = 1'b1;
      end
      StFin:   done = 1'b1;
      default: ;
    endcase
  end

  assign dump_addr = r_addr;

  uart_tx_8n1 #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart (
    .clk       (clk),
    .rst       (rst),
    .start     (w_uart_start),
    .data      (w_uart_data),
    .tx        (tx),
    .busy      (w_uart_busy),
    .byte_done (w_byte_done)
  );

  logic w_unused;
  assign w_unused = w_uart_busy;

endmodule

// File: tb/tb_dram_dump_reader.sv
// Bench for dram_dump_reader: three instances (normal window, wrapping window,
// empty window) against a behavioural 1-cycle-latency DRAM and a UART decoder.
module tb_dram_dump_reader;

  localparam int unsigned Cpb        = 4;
  localparam int unsigned WordCycles = 40 * Cpb + 1 + 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  end_r;
  wire  [2:0]  tx_w, sel_w, busy_w, done_w;
  wire  [11:0] addr_w [3];
  logic [31:0] q_r [3];
  logic [31:0] mem [4096];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dram_dump_reader #(
    .START_ADDR (12'h000), .WORD_COUNT (13'd2), .CLKS_PER_BIT (Cpb), .RD_LAT (1)
  ) u_dut_a (
    .clk (clk), .rst (rst), .End (end_r[0]), .q (q_r[0]), .dump_addr (addr_w[0]),
    .dump_sel (sel_w[0]), .busy (busy_w[0]), .done (done_w[0]), .tx (tx_w[0])
  );

  dram_dump_reader #(
    .START_ADDR (12'hFFF), .WORD_COUNT (13'd2), .CLKS_PER_BIT (Cpb), .RD_LAT (1)
  ) u_dut_b (
    .clk (clk), .rst (rst), .End (end_r[1]), .q (q_r[1]), .dump_addr (addr_w[1]),
    .dump_sel (sel_w[1]), .busy (busy_w[1]), .done (done_w[1]), .tx (tx_w[1])
  );

  dram_dump_reader #(
    .START_ADDR (12'h000), .WORD_COUNT (13'd0), .CLKS_PER_BIT (Cpb), .RD_LAT (1)
  ) u_dut_c (
    .clk (clk), .rst (rst), .End (end_r[2]), .q (q_r[2]), .dump_addr (addr_w[2]),
    .dump_sel (sel_w[2]), .busy (busy_w[2]), .done (done_w[2]), .tx (tx_w[2])
  );

  // Behavioural DRAM: address muxed by dump_sel as the top level would, 1-cycle read.
  always @(posedge clk) begin
    q_r[0] <= mem[sel_w[0] ? addr_w[0] : 12'h000];
    q_r[1] <= mem[sel_w[1] ? addr_w[1] : 12'h000];
    q_r[2] <= mem[sel_w[2] ? addr_w[2] : 12'h000];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Raise End on one instance and check the whole dump against the model.
  task automatic run_dump(input int inst, input logic [11:0] start, input int wc,
                          input bit glitch_end);
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    int          gap_q[$];
    int          done_at = -1;
    int          done_cnt = 0;
    int          sel_bad = 0;
    int          addr_bad = 0;
    int          frame_bad = 0;
    int          nbytes;
    logic [31:0] word;
    logic [11:0] a;

    for (int i = 0; i < wc; i++) begin
      a    = start + 12'(i);
      word = mem[a];
      exp_q.push_back(word[31:24]);
      exp_q.push_back(word[23:16]);
      exp_q.push_back(word[15:8]);
      exp_q.push_back(word[7:0]);
    end
    nbytes = exp_q.size();

    @(negedge clk);
    end_r[inst] = 1'b1;
    fork
      begin
        for (int n = 1; n <= wc * int'(WordCycles) + 40; n++) begin
          @(negedge clk);
          if (done_w[inst]) begin
            done_cnt++;
            if (done_at < 0) done_at = n;
          end
          if (wc == 0) begin
            if (sel_w[inst] || busy_w[inst] || !tx_w[inst]) sel_bad++;
          end else if (n <= wc * int'(WordCycles)) begin
            if (!sel_w[inst] || !busy_w[inst]) sel_bad++;
            if ((n - 1) % int'(WordCycles) == 0 &&
                addr_w[inst] !== start + 12'((n - 1) / int'(WordCycles))) addr_bad++;
          end else if (sel_w[inst] || busy_w[inst]) begin
            sel_bad++;
          end
        end
      end
      begin
        for (int b = 0; b < nbytes; b++) begin
          int         t = 0;
          logic [7:0] d;
          while (tx_w[inst] !== 1'b0 && t < 400) begin
            @(negedge clk);
            t++;
          end
          if (t >= 400) break;
          gap_q.push_back(t);
          repeat (Cpb / 2) @(negedge clk);
          if (tx_w[inst] !== 1'b0) frame_bad++;
          for (int i = 0; i < 8; i++) begin
            repeat (Cpb) @(negedge clk);
            d[i] = tx_w[inst];
          end
          repeat (Cpb) @(negedge clk);
          if (tx_w[inst] !== 1'b1) frame_bad++;
          got_q.push_back(d);
          repeat (Cpb / 2) @(negedge clk);
        end
      end
      begin
        if (glitch_end) begin
          repeat ($urandom_range(20, 200)) @(negedge clk);
          end_r[inst] = 1'b0;
          repeat ($urandom_range(1, 30)) @(negedge clk);
          end_r[inst] = 1'b1;
        end
      end
    join

    check_eq($sformatf("i%0d byte_count", inst), 64'(got_q.size()), 64'(nbytes));
    for (int b = 0; b < got_q.size() && b < nbytes; b++) begin
      check_eq($sformatf("i%0d byte%0d", inst, b), 64'(got_q[b]), 64'(exp_q[b]));
      // Frames inside a word are back-to-back; each word starts 4 cycles after the last stop bit.
      check_eq($sformatf("i%0d gap%0d", inst, b), 64'(gap_q[b]), (b % 4 == 0) ? 64'd4 : 64'd0);
    end
    check_eq($sformatf("i%0d done_count", inst), 64'(done_cnt), 64'd1);
    check_eq($sformatf("i%0d done_cycle", inst), 64'(done_at), 64'(wc * int'(WordCycles) + 1));
    check_eq($sformatf("i%0d sel_busy_window", inst), 64'(sel_bad), 64'd0);
    check_eq($sformatf("i%0d addr_seq", inst), 64'(addr_bad), 64'd0);
    check_eq($sformatf("i%0d framing", inst), 64'(frame_bad), 64'd0);
  endtask

  initial begin
    int bad;
    int k;
    int inst;

    rst   = 1'b1;
    end_r = 3'b000;
    for (int a = 0; a < 4096; a++) mem[a] = 32'hA500_0000 | 32'(a);

    repeat (2) @(negedge clk);
    check_eq("reset_tx", 64'(tx_w), 64'h7);
    check_eq("reset_sel", 64'(sel_w), 64'h0);
    check_eq("reset_busy", 64'(busy_w), 64'h0);
    check_eq("reset_done", 64'(done_w), 64'h0);
    check_eq("reset_addr_a", 64'(addr_w[0]), 64'h000);
    check_eq("reset_addr_b", 64'(addr_w[1]), 64'hFFF);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Basic two-word dump.
    run_dump(0, 12'h000, 2, 1'b0);

    // End held high after completion must not retrigger.
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (busy_w[0] || done_w[0] || sel_w[0] || !tx_w[0]) bad++;
    end
    check_eq("hold_high_no_retrigger", 64'(bad), 64'd0);
    end_r[0] = 1'b0;
    repeat ($urandom_range(3, 20)) @(negedge clk);
    run_dump(0, 12'h000, 2, 1'b0);
    end_r[0] = 1'b0;

    // Address window wrapping past 4095.
    repeat ($urandom_range(3, 20)) @(negedge clk);
    run_dump(1, 12'hFFF, 2, 1'b0);
    end_r[1] = 1'b0;

    // Empty window.
    repeat ($urandom_range(3, 20)) @(negedge clk);
    run_dump(2, 12'h000, 0, 1'b0);
    end_r[2] = 1'b0;

    // End toggled while busy is ignored.
    repeat ($urandom_range(3, 20)) @(negedge clk);
    run_dump(0, 12'h000, 2, 1'b1);
    end_r[0] = 1'b0;

    // Reset during byte 2 of word 0 (that byte is 8'h00, so tx is low in start/data bits).
    repeat (5) @(negedge clk);
    end_r[0] = 1'b1;
    k = 44 + int'($urandom_range(0, 30));
    repeat (k) @(negedge clk);
    check_eq("tx_low_before_rst", 64'(tx_w[0]), 64'd0);
    rst = 1'b1;
    #1;
    check_eq("rst_tx", 64'(tx_w[0]), 64'd1);
    check_eq("rst_busy", 64'(busy_w[0]), 64'd0);
    check_eq("rst_sel", 64'(sel_w[0]), 64'd0);
    check_eq("rst_done", 64'(done_w[0]), 64'd0);
    check_eq("rst_addr", 64'(addr_w[0]), 64'h000);
    repeat (3) @(negedge clk);
    end_r[0] = 1'b0;
    rst      = 1'b0;
    bad      = 0;
    repeat (300) begin
      @(negedge clk);
      if (done_w[0] || busy_w[0] || !tx_w[0]) bad++;
    end
    check_eq("post_rst_quiet", 64'(bad), 64'd0);
    run_dump(0, 12'h000, 2, 1'b0);
    end_r[0] = 1'b0;

    // Random DRAM contents in both windows.
    for (int r = 0; r < 4; r++) begin
      mem[12'h000] = $urandom;
      mem[12'h001] = $urandom;
      mem[12'hFFF] = $urandom;
      inst = r % 2;
      repeat ($urandom_range(3, 40)) @(negedge clk);
      run_dump(inst, (inst == 1) ? 12'hFFF : 12'h000, 2, r[1]);
      end_r[inst] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
